// File: rtl/univ_pkg.sv
// Shared constants for the universal shift register / counter.
// Mode encodings are used by both the RTL and the bench.
package univ_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROTL = 3'b100,
    MODE_ROTR = 3'b101,
    MODE_UP   = 3'b110,
    MODE_DOWN = 3'b111
  } mode_e;

endpackage

// File: rtl/univ_shift_counter_if.sv
// Control/data bundle for univ_shift_counter.
// The master drives the controls; the slave returns state and flags.
interface univ_shift_counter_if #(
  parameter int WIDTH = 4
);

  logic             en;
  logic [2:0]       mode;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             zero;

  modport master (
    output en, mode, sin_l, sin_r, d,
    input  q, tc, zero
  );

  modport slave (
    input  en, mode, sin_l, sin_r, d,
    output q, tc, zero
  );

endinterface

// File: rtl/univ_shift_counter.sv
// Universal register: hold, load, shift, rotate, up/down count.
// Q is the only state; tc and zero are decoded from Q and mode.
module univ_shift_counter
  import univ_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             zero
);

  localparam logic [31:0]      RST_W = RST_VAL;
  localparam logic [WIDTH-1:0] RST_Q = RST_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: q_d = D;
        MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_r};
        MODE_SHR:  q_d = {sin_l, q_q[WIDTH-1:1]};
        MODE_ROTL: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROTR: q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_UP:   q_d = q_q + ONE;
        MODE_DOWN: q_d = q_q - ONE;
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r) q_q <= RST_Q;
    else   q_q <= q_d;
  end

  // tc looks at mode only, so it flags the wrap even while en is low
  always_comb begin
    tc = 1'b0;
    if (mode == MODE_UP)   tc = &q_q;
    if (mode == MODE_DOWN) tc = ~|q_q;
  end

  assign zero = ~|q_q;
  assign Q    = q_q;

endmodule
